mel_frame_sequencer: RTL and testbench

- Sits between the FFT power stream and the 40-band mel filterbank.
- Forwards one frame of N_BINS power beats into the filterbank and keeps the filterbank's bin counter aligned to frame boundaries, padding with zero bins on a mid-frame start-of-frame.
- Two cycles after the last bin is accepted, snapshots the N_MELS accumulators, then drains them one per cycle over a ready/valid stream to the log stage.
- Draining overlaps with feeding the next frame.

---
 rtl/mel_frame_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_mel_frame_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mel_frame_sequencer
//
// Sits between the FFT power stream and the mel filterbank. Forwards one frame
// of N_BINS power beats to the filterbank and keeps its bin counter aligned to
// frame boundaries. A start-of-frame that arrives mid-frame is held off while
// the remaining bins are padded with zeros, and that padded frame is discarded.
// Two cycles after the last bin is issued, the N_MELS accumulators are
// snapshotted. The snapshot is then drained one band per cycle over a
// ready/valid stream. Draining overlaps with feeding the next frame.
//
// Optional feature: define MEL_SEQ_SAT_EN to saturate each shifted accumulator
// to OUT_W bits. Without it, the low OUT_W bits are taken.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   power_i      upstream power bin
//   valid_i      upstream beat valid
//   sof_i        beat is bin 0 of a frame (qualified by valid_i)
//   ready_o      upstream beat accepted when valid_i && ready_o
//   fb_power_o   registered power to filterbank
//   fb_valid_o   registered bin strobe to filterbank
//   fb_mel_i     filterbank accumulator array
//   mel_o        drained mel value
//   mel_idx_o    band index of mel_o
//   mel_valid_o  drain valid
//   mel_last_o   high with band N_MELS-1
//   mel_ready_i  downstream ready
//   err_o        sticky: mid-frame sof_i seen
// -----------------------------------------------------------------------------
module mel_frame_sequencer #(
  parameter int N_MELS  = 40,
  parameter int N_BINS  = 129,
  parameter int POWER_W = 31,
  parameter int ACCUM_W = 54,
  parameter int OUT_W   = 32,
  parameter int SHIFT   = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [POWER_W-1:0]               power_i,
  input  logic                             valid_i,
  input  logic                             sof_i,
  output logic                             ready_o,
  output logic [POWER_W-1:0]               fb_power_o,
  output logic                             fb_valid_o,
  input  logic [N_MELS-1:0][ACCUM_W-1:0]   fb_mel_i,
  output logic [OUT_W-1:0]                 mel_o,
  output logic [5:0]                       mel_idx_o,
  output logic                             mel_valid_o,
  output logic                             mel_last_o,
  input  logic                             mel_ready_i,
  output logic                             err_o
);

  localparam int                BIN_W    = $clog2(N_BINS);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(N_BINS - 1);
  localparam logic [5:0]        LAST_MEL = 6'(N_MELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAD, S_FLUSH, S_CAP} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_cnt_q;
  logic               discard_q;
  logic               snap_full_q;
  logic [5:0]         idx_q;
  logic [ACCUM_W-1:0] snap_q [N_MELS];

  logic last_bin;
  logic held_sof;
  logic cap_write;
  logic accept;
  logic drain_hs;

  assign last_bin = (bin_cnt_q == LAST_BIN);
  assign accept   = valid_i && ready_o;
  assign drain_hs = snap_full_q && mel_ready_i;

  // ---------------------------------------------------------------------------
  // Feed FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Feed FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (valid_i && sof_i) state_d = S_RUN;
      S_RUN: begin
        if (valid_i && sof_i)          state_d = S_PAD;
        else if (accept && last_bin)   state_d = S_FLUSH;
      end
      S_PAD:   if (last_bin) state_d = S_FLUSH;
      S_FLUSH: state_d = S_CAP;
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Feed FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_o   = 1'b0;
    held_sof  = 1'b0;
    cap_write = 1'b0;
    unique case (state_q)
      S_IDLE: ready_o = 1'b1;
      S_RUN: begin
        held_sof = valid_i && sof_i;
        // The last bin waits for the previous snapshot to drain so CAP never
        // overwrites it. snap_full_q is registered, so the stall lasts at
        // least one cycle even when the drain finishes this cycle.
        ready_o  = !held_sof && !(last_bin && snap_full_q);
      end
      S_CAP:   cap_write = !discard_q;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding to the filterbank, bin counter, discard and error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bin_cnt_q  <= '0;
      discard_q  <= 1'b0;
      err_o      <= 1'b0;
      fb_valid_o <= 1'b0;
      fb_power_o <= '0;
    end else begin
      fb_valid_o <= 1'b0;
      fb_power_o <= '0;
      if (held_sof) err_o <= 1'b1;

      if (state_q == S_PAD) begin
        // Zero bins keep the filterbank counter frame-aligned; this frame is
        // never snapshotted.
        fb_valid_o <= 1'b1;
        if (last_bin) begin
          bin_cnt_q <= '0;
          discard_q <= 1'b1;
        end else begin
          bin_cnt_q <= bin_cnt_q + BIN_W'(1);
        end
      end else if (accept && (state_q == S_RUN || sof_i)) begin
        // Non-sof beats in IDLE are consumed but not forwarded.
        fb_valid_o <= 1'b1;
        fb_power_o <= power_i;
        if (state_q == S_IDLE) begin
          bin_cnt_q <= BIN_W'(1);
        end else if (last_bin) begin
          bin_cnt_q <= '0;
          discard_q <= 1'b0;
        end else begin
          bin_cnt_q <= bin_cnt_q + BIN_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot ownership and drain pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      snap_full_q <= 1'b0;
      idx_q       <= '0;
    end else if (cap_write) begin
      snap_full_q <= 1'b1;
      idx_q       <= '0;
    end else if (drain_hs) begin
      if (mel_last_o) begin
        snap_full_q <= 1'b0;
        idx_q       <= '0;
      end else begin
        idx_q <= idx_q + 6'd1;
      end
    end
  end

  // NOTE: the snapshot storage has no reset; snap_full_q alone says whether
  // its contents are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clk_i) begin
    if (cap_write) begin
      for (int m = 0; m < N_MELS; m++) snap_q[m] <= fb_mel_i[m];
    end
  end

  // ---------------------------------------------------------------------------
  // Drain outputs
  // ---------------------------------------------------------------------------
  assign mel_valid_o = snap_full_q;
  assign mel_idx_o   = idx_q;
  assign mel_last_o  = (idx_q == LAST_MEL);

`ifdef MEL_SEQ_SAT_EN
  logic [ACCUM_W-1:0] shifted;
  assign shifted = snap_q[idx_q] >> SHIFT;
  assign mel_o   = (|shifted[ACCUM_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`else
  assign mel_o   = OUT_W'(snap_q[idx_q] >> SHIFT);
`endif

endmodule

// File: tb/tb_mel_frame_sequencer.sv
module tb_mel_frame_sequencer;

  localparam int N_MELS  = 40;
  localparam int N_BINS  = 129;
  localparam int POWER_W = 31;
  localparam int ACCUM_W = 54;
  localparam int OUT_W   = 32;

  logic                           clk_i = 1'b0;
  logic                           reset_i;
  logic [POWER_W-1:0]             power_i;
  logic                           valid_i;
  logic                           sof_i;
  logic                           ready_o;
  logic [POWER_W-1:0]             fb_power_o;
  logic                           fb_valid_o;
  logic [N_MELS-1:0][ACCUM_W-1:0] fb_mel_i;
  logic [OUT_W-1:0]               mel_o;
  logic [5:0]                     mel_idx_o;
  logic                           mel_valid_o;
  logic                           mel_last_o;
  logic                           mel_ready_i;
  logic                           err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mel_frame_sequencer dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .power_i     (power_i),
    .valid_i     (valid_i),
    .sof_i       (sof_i),
    .ready_o     (ready_o),
    .fb_power_o  (fb_power_o),
    .fb_valid_o  (fb_valid_o),
    .fb_mel_i    (fb_mel_i),
    .mel_o       (mel_o),
    .mel_idx_o   (mel_idx_o),
    .mel_valid_o (mel_valid_o),
    .mel_last_o  (mel_last_o),
    .mel_ready_i (mel_ready_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Filterbank model: accumulators are valid only in the single cycle after
  // the bin strobe falls; any other cycle shows a junk pattern, so a snapshot
  // taken one cycle early or late is visible in the drained values.
  logic [ACCUM_W-1:0] good [N_MELS];
  logic               fbv_d = 1'b0;
  logic [ACCUM_W-1:0] junk;
  assign junk = {27{2'b10}};

  always_comb begin
    for (int m = 0; m < N_MELS; m++)
      fb_mel_i[m] = (fbv_d && !fb_valid_o) ? good[m] : junk;
  end

  // Monitor: counts filterbank strobes, records drained beats, and flags any
  // change of mel outputs while stalled.
  int          fb_cnt     = 0;
  int          zero_cnt   = 0;
  int          stall_viol = 0;
  logic [38:0] rec_q [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_mel   = '0;
  logic [5:0]  prev_idx   = '0;

  always @(posedge clk_i) begin
    fbv_d <= reset_i ? 1'b0 : fb_valid_o;
    if (!reset_i) begin
      if (fb_valid_o) begin
        fb_cnt++;
        if (fb_power_o == '0) zero_cnt++;
      end
      if (mel_valid_o && mel_ready_i) rec_q.push_back({mel_last_o, mel_idx_o, mel_o});
      if (prev_stall && (!mel_valid_o || mel_o != prev_mel || mel_idx_o != prev_idx))
        stall_viol++;
    end
    prev_stall <= mel_valid_o && !mel_ready_i && !reset_i;
    prev_mel   <= mel_o;
    prev_idx   <= mel_idx_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_good(input int off);
    for (int m = 0; m < N_MELS; m++) good[m] = ACCUM_W'(m + off) << 16;
  endtask

  // Presents one beat and waits (bounded) until it is accepted.
  task automatic send_beat(input logic sof, input logic [POWER_W-1:0] pw, output bit ok);
    int guard = 0;
    valid_i = 1'b1;
    sof_i   = sof;
    power_i = pw;
    #1;
    while (!ready_o && guard < 1000) begin
      tick();
      guard++;
    end
    ok = ready_o;
    tick();
  endtask

  task automatic send_frame(input int n, input logic first_sof, input logic [POWER_W-1:0] pw,
                            input string tag);
    int bad = 0;
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_beat(first_sof && (i == 0), pw, ok);
      if (!ok) bad++;
    end
    valid_i = 1'b0;
    sof_i   = 1'b0;
    check(tag, 64'(bad), 64'd0);
  endtask

  // mode 0: mel_ready_i held high; mode 1: high one cycle in three.
  task automatic wait_drain(input int n_expected, input int mode, input string tag);
    int guard = 0;
    while (rec_q.size() < n_expected && guard < 2000) begin
      mel_ready_i = (mode == 0) || (guard % 3 == 0);
      tick();
      guard++;
    end
    mel_ready_i = 1'b1;
    check(tag, 64'(rec_q.size()), 64'(n_expected));
  endtask

  task automatic check_frame(input int base, input int off, input string tag);
    logic [38:0] r;
    for (int m = 0; m < N_MELS; m++) begin
      r = rec_q[base + m];
      check({tag, "_val"},  64'(r[31:0]),  64'(m + off));
      check({tag, "_idx"},  64'(r[37:32]), 64'(m));
      check({tag, "_last"}, 64'(r[38]),    64'(m == N_MELS - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base_q, base_fb, base_z, guard;
    bit  ok;
    logic [31:0] sat_exp;

    reset_i = 1'b1; valid_i = 1'b0; sof_i = 1'b0; power_i = '0; mel_ready_i = 1'b0;
    set_good(0);
    tick(); tick(); tick();

    // Reset state
    check("rst_ready",     64'(ready_o),     64'd1);
    check("rst_fb_valid",  64'(fb_valid_o),  64'd0);
    check("rst_fb_power",  64'(fb_power_o),  64'd0);
    check("rst_mel_valid", 64'(mel_valid_o), 64'd0);
    check("rst_mel_idx",   64'(mel_idx_o),   64'd0);
    check("rst_err",       64'(err_o),       64'd0);
    reset_i = 1'b0;
    tick();

    // Single frame, downstream always ready
    set_good(0);
    mel_ready_i = 1'b1;
    base_q = rec_q.size(); base_fb = fb_cnt; base_z = zero_cnt;
    send_frame(N_BINS, 1'b1, 31'd1, "t1_accept");
    check("t1_flush_fbv",   64'(fb_valid_o), 64'd1);
    check("t1_flush_ready", 64'(ready_o),    64'd0);
    tick();
    check("t1_cap_fbv",     64'(fb_valid_o), 64'd0);
    tick();
    check("t1_mel_valid",   64'(mel_valid_o), 64'd1);
    wait_drain(base_q + N_MELS, 0, "t1_drain");
    check("t1_fb_count",    64'(fb_cnt - base_fb),  64'(N_BINS));
    check("t1_zero_count",  64'(zero_cnt - base_z), 64'd0);
    check_frame(base_q, 0, "t1");
    check("t1_err",         64'(err_o), 64'd0);

    // Same frame, downstream ready one cycle in three
    mel_ready_i = 1'b0;
    base_q = rec_q.size();
    send_frame(N_BINS, 1'b1, 31'd1, "t2_accept");
    wait_drain(base_q + N_MELS, 1, "t2_drain");
    check_frame(base_q, 0, "t2");
    check("t2_stable", 64'(stall_viol), 64'd0);

    // Back-to-back frames; last bin of frame B stalls until A drains
    mel_ready_i = 1'b0;
    base_q = rec_q.size();
    set_good(1);
    send_frame(N_BINS, 1'b1, 31'd1, "t3_frame_a");
    send_beat(1'b1, 31'd1, ok);
    check("t3_sof_b", 64'(ok), 64'd1);
    set_good(50);
    send_frame(N_BINS - 2, 1'b0, 31'd1, "t3_frame_b");
    valid_i = 1'b1; sof_i = 1'b0; power_i = 31'd1;
    #1;
    check("t3_stall0", 64'(ready_o), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t3_stall", 64'(ready_o), 64'd0);
    end
    check("t3_hold_valid", 64'(mel_valid_o), 64'd1);
    check("t3_hold_idx",   64'(mel_idx_o),   64'd0);
    check("t3_hold_mel",   64'(mel_o),       64'd1);
    mel_ready_i = 1'b1;
    guard = 0;
    while (!ready_o && guard < 200) begin
      tick();
      guard++;
    end
    check("t3_resume",        64'(ready_o),      64'd1);
    check("t3_a_drained",     64'(rec_q.size()), 64'(base_q + N_MELS));
    tick();
    valid_i = 1'b0;
    wait_drain(base_q + 2 * N_MELS, 0, "t3_drain");
    check_frame(base_q, 1, "t3a");
    check_frame(base_q + N_MELS, 50, "t3b");

    // Mid-frame sof at bin 50: pad, discard, then restart cleanly
    check("t4_err_before", 64'(err_o), 64'd0);
    set_good(99);
    base_q = rec_q.size(); base_fb = fb_cnt; base_z = zero_cnt;
    send_frame(50, 1'b1, 31'd1, "t4_partial");
    valid_i = 1'b1; sof_i = 1'b1; power_i = 31'd7;
    #1;
    check("t4_held_ready", 64'(ready_o), 64'd0);
    tick();
    check("t4_err",        64'(err_o),      64'd1);
    check("t4_pad_first",  64'(fb_valid_o), 64'd0);
    tick();
    check("t4_pad_fbv",    64'(fb_valid_o), 64'd1);
    check("t4_pad_power",  64'(fb_power_o), 64'd0);
    check("t4_pad_ready",  64'(ready_o),    64'd0);
    guard = 0;
    while (!ready_o && guard < 200) begin
      tick();
      guard++;
    end
    check("t4_release",    64'(ready_o),             64'd1);
    check("t4_fb_count",   64'(fb_cnt - base_fb),    64'(N_BINS));
    check("t4_pad_count",  64'(zero_cnt - base_z),   64'(N_BINS - 50));
    check("t4_no_drain",   64'(mel_valid_o),         64'd0);
    set_good(7);
    tick();
    valid_i = 1'b0; sof_i = 1'b0;
    check("t4_sof_fwd_v",  64'(fb_valid_o), 64'd1);
    check("t4_sof_fwd_p",  64'(fb_power_o), 64'd7);
    send_frame(N_BINS - 1, 1'b0, 31'd1, "t4_clean");
    wait_drain(base_q + N_MELS, 0, "t4_drain");
    check_frame(base_q, 7, "t4");
    tick(); tick(); tick();
    check("t4_single_drain", 64'(rec_q.size()), 64'(base_q + N_MELS));
    check("t4_err_sticky",   64'(err_o),        64'd1);

    // Band 0 overflows OUT_W after the shift
`ifdef MEL_SEQ_SAT_EN
    sat_exp = 32'hFFFF_FFFF;
`else
    sat_exp = 32'h0000_0000;
`endif
    mel_ready_i = 1'b0;
    set_good(0);
    good[0] = ACCUM_W'(1) << 50;
    base_q = rec_q.size();
    send_frame(N_BINS, 1'b1, 31'd3, "t5_accept");
    tick(); tick();
    check("t5_valid",      64'(mel_valid_o), 64'd1);
    check("t5_sat",        64'(mel_o),       64'(sat_exp));
    tick(); tick();
    check("t5_sat_stable", 64'(mel_o),       64'(sat_exp));
    check("t5_idx_stable", 64'(mel_idx_o),   64'd0);
    wait_drain(base_q + N_MELS, 0, "t5_drain");
    check("t5_band0", 64'(rec_q[base_q][31:0]),     64'(sat_exp));
    check("t5_band1", 64'(rec_q[base_q + 1][31:0]), 64'd1);
    check("t5_band39_last", 64'(rec_q[base_q + 39][38]), 64'd1);

    // Reset clears the sticky error; non-sof beats in IDLE are dropped
    reset_i = 1'b1;
    tick();
    check("t6_rst_err",   64'(err_o),       64'd0);
    check("t6_rst_ready", 64'(ready_o),     64'd1);
    reset_i = 1'b0;
    tick();
    base_fb = fb_cnt;
    send_frame(5, 1'b0, 31'd5, "t6_idle_accept");
    tick(); tick();
    check("t6_no_fwd",     64'(fb_cnt - base_fb), 64'd0);
    check("t6_fbv_low",    64'(fb_valid_o),       64'd0);
    check("t6_mel_valid",  64'(mel_valid_o),      64'd0);
    check("t6_stable_all", 64'(stall_viol),       64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
